// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory request scheduler: the idle read-data
// pattern, a pointer-width helper and the registered response descriptor.
package mem_sched_pkg;

  localparam logic [31:0] DEADBEEF = 32'hdeadbeef;

  // Upper bound on requesters; response vectors are sized to this.
  localparam int MAX_NUM = 8;

  // Width of an index over n requesters, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Response owed next cycle: RAM owner (one-hot), RAM read flag and the
  // set of masters receiving a decode-error response.
  typedef struct packed {
    logic [MAX_NUM-1:0] sel;
    logic               rd;
    logic [MAX_NUM-1:0] err;
  } resp_t;

endpackage

// File: rtl/mem_sched_rr_pick.sv
// Round-robin pick: grants the first eligible requester at or above ptr,
// wrapping from NUM-1 back to 0. Purely combinational.
module mem_sched_rr_pick
  import mem_sched_pkg::*;
#(
  parameter int NUM = 2,
  parameter int PW  = clog2(NUM)
) (
  input  logic [NUM-1:0] elig,
  input  logic [PW-1:0]  ptr,
  output logic [NUM-1:0] gnt,
  output logic [PW-1:0]  idx,
  output logic           any
);

  int best;
  int best_d;
  int d;

  // Choose the eligible requester with the smallest distance from ptr.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    best   = 0;
    best_d = NUM;
    d      = 0;
    for (int i = 0; i < NUM; i++) begin
      d = (i + NUM - int'(ptr)) % NUM;
      if (elig[i] && (d < best_d)) begin
        best_d = d;
        best   = i;
        any    = 1'b1;
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (any && (i == best)) begin
        gnt[i] = 1'b1;
        idx    = PW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Shares one single-port SRAM (1-cycle read latency) between NUM masters
// with round-robin arbitration, and routes each response to its owner.
// Optional feature macro: MEM_SCHED_DECERR_EN -- out-of-window requests are
// granted immediately and answered with err_o=1 without touching the RAM.
module mem_req_scheduler
  import mem_sched_pkg::*;
#(
  parameter int          NUM    = 2,
  parameter int          MEM_AW = 16,
  parameter logic [31:0] ADDR_L = 32'h0000_0000,
  parameter logic [31:0] ADDR_H = 32'h0003_ffff
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM-1:0]    req_i,
  input  logic [NUM-1:0]    req_wr_i,
  input  logic [NUM*32-1:0] req_addr_i,
  input  logic [NUM*32-1:0] req_wdata_i,
  input  logic [NUM*4-1:0]  req_be_i,
  output logic [NUM-1:0]    gnt_o,
  output logic [NUM-1:0]    rvalid_o,
  output logic [NUM*32-1:0] rdata_o,
  output logic [NUM-1:0]    err_o,
  input  logic              mem_ready_i,
  output logic              mem_en_o,
  output logic              mem_wr_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int            PW   = clog2(NUM);
  localparam logic [PW-1:0] LAST = PW'(NUM - 1);

  logic [PW-1:0]  rr_ptr;
  logic [NUM-1:0] win;
  logic [NUM-1:0] elig;
  logic [NUM-1:0] pick_gnt;
  logic [PW-1:0]  pick_idx;
  logic           pick_any;
  logic           ram_any;
  logic [NUM-1:0] ram_gnt;
  logic [NUM-1:0] dec_gnt;
  resp_t          resp_d;
  resp_t          resp_p1;

`ifdef MEM_SCHED_DECERR_EN
  // Single unsigned compare covers both window edges, ADDR_H inclusive.
  function automatic logic in_window(input logic [31:0] a);
    return (a - ADDR_L) <= (ADDR_H - ADDR_L);
  endfunction

  // Address decode per master.
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM; i++) win[i] = in_window(req_addr_i[32*i +: 32]);
  end

  assign dec_gnt = req_i & ~win & {NUM{~reset_n}};
`else
  logic unused_addr;

  // No decode: every address wraps into the RAM through its word bits.
  assign win     = '1;
  assign dec_gnt = '0;

  // Byte-offset and high address bits are not decoded in this build.
  always_comb begin
    unused_addr = (ADDR_L > ADDR_H);
    for (int i = 0; i < NUM; i++) begin
      unused_addr = unused_addr ^ (^req_addr_i[32*i +: 2])
                                ^ (^req_addr_i[32*i+MEM_AW+2 +: 30-MEM_AW]);
    end
  end
`endif

  assign elig = req_i & win;

  mem_sched_rr_pick #(
    .NUM (NUM),
    .PW  (PW)
  ) u_pick (
    .elig (elig),
    .ptr  (rr_ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Grants are suppressed while reset is held or the RAM is not ready.
  assign ram_any  = pick_any & mem_ready_i & ~reset_n;
  assign ram_gnt  = pick_gnt & {NUM{ram_any}};
  assign gnt_o    = ram_gnt | dec_gnt;
  assign mem_en_o = ram_any;

  // Steer the granted master's payload onto the RAM port.
  always_comb begin
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = 4'hf;
    for (int i = 0; i < NUM; i++) begin
      if (ram_gnt[i]) begin
        mem_wr_o    = req_wr_i[i];
        mem_addr_o  = req_addr_i[32*i+2 +: MEM_AW];
        mem_wdata_o = req_wdata_i[32*i +: 32];
        mem_be_o    = req_wr_i[i] ? req_be_i[4*i +: 4] : 4'hf;
      end
    end
  end

  // Round-robin pointer moves past the RAM winner; holds otherwise.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rr_ptr <= '0;
    end else if (ram_any) begin
      rr_ptr <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
    end
  end

  // Describe the response owed next cycle.
  always_comb begin
    resp_d              = '0;
    resp_d.sel[NUM-1:0] = ram_gnt;
    resp_d.rd           = ram_any & ~mem_wr_o;
    resp_d.err[NUM-1:0] = dec_gnt;
  end

  // ---- stage boundary: grant cycle -> response cycle (p1) ----
  // Response ownership register; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      resp_p1 <= '0;
    end else begin
      resp_p1 <= resp_d;
    end
  end

  // Deliver responses to their owners; RAM data only to a read owner.
  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = {NUM{DEADBEEF}};
    for (int i = 0; i < NUM; i++) begin
      rvalid_o[i] = ~reset_n & (resp_p1.sel[i] | resp_p1.err[i]);
      err_o[i]    = ~reset_n & resp_p1.err[i];
      if (~reset_n & resp_p1.sel[i] & resp_p1.rd) rdata_o[32*i +: 32] = mem_rdata_i;
    end
  end

  if (NUM < MAX_NUM) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{resp_p1.sel[MAX_NUM-1:NUM], resp_p1.err[MAX_NUM-1:NUM]};
  end

endmodule
